// File: rtl/if_axis_tx_if.sv
// CPU peripheral bus plus AXI-stream master bundle for if_axis_tx.
// slave = the transmitter block; master = CPU / stream consumer side driving it.
// Backpressure is carried by m_axis_tready_i; the CPU side has none (full writes are dropped).
`timescale 1ns/1ps
interface if_axis_tx_if #(
  parameter int AXIS_DATA_WIDTH = 8
) ();
  logic [31:0]                addr_i;
  logic [31:0]                data_i;
  logic [31:0]                data_o;
  logic                       data_access_o;
  logic                       data_w_i;
  logic                       m_axis_tvalid_o;
  logic                       m_axis_tready_i;
  logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o;
  logic                       m_axis_tlast_o;

  modport slave (
    input  addr_i, data_i, data_w_i, m_axis_tready_i,
    output data_o, data_access_o, m_axis_tvalid_o, m_axis_tdata_o, m_axis_tlast_o
  );

  modport master (
    output addr_i, data_i, data_w_i, m_axis_tready_i,
    input  data_o, data_access_o, m_axis_tvalid_o, m_axis_tdata_o, m_axis_tlast_o
  );
endinterface

// File: rtl/if_axis_tx.sv
// CPU-written byte FIFO driven out as an AXI-stream master; optional tlast via AXIS_TX_TLAST_EN.
// Latency: TXDATA write at edge N -> tvalid after edge N+1; STATUS reads land on data_o one edge later.
// Backpressure: tready low holds the output slot; FIFO fills, then further writes drop and set overflow.
`timescale 1ns/1ps
module if_axis_tx #(
  parameter logic [7:0] SOC_SEGMENT     = 8'hE4,
  parameter logic [7:0] SOC_CLASS       = 8'hA9,
  parameter int         AXIS_DATA_WIDTH = 8,
  parameter int         FIFO_DEPTH      = 4
) (
  input  logic         axis_aclk_i,
  input  logic         axis_aresetn_i,
  if_axis_tx_if.slave  bus
);
  localparam int DW = AXIS_DATA_WIDTH;
`ifdef AXIS_TX_TLAST_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] OFF_STATUS = 3'b001;
  localparam logic [2:0] OFF_TXDATA = 3'b010;
  localparam logic [2:0] OFF_CTRL   = 3'b011;

  logic          access;
  logic [2:0]    sel;
  logic          txdata_wr;
  logic          ctrl_wr;
  logic          flush;
  logic          clr_sticky;

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [FW-1:0] push_dat;
  logic [FW-1:0] head_dat;
  logic          do_push;
  logic          load;

  logic          overflow;
  logic          last_sent;
  logic          tvalid_q;
  logic [DW-1:0] tdata_q;
  logic          tlast_q;
  logic [31:0]   status;
  logic [31:0]   data_q;
  logic          unused_bits;

  assign access     = (bus.addr_i[31:24] == SOC_SEGMENT) && (bus.addr_i[23:16] == SOC_CLASS);
  assign sel        = bus.addr_i[6:4];
  assign txdata_wr  = access && bus.data_w_i && (sel == OFF_TXDATA);
  assign ctrl_wr    = access && bus.data_w_i && (sel == OFF_CTRL);
  assign flush      = ctrl_wr && bus.data_i[0];
  assign clr_sticky = ctrl_wr && bus.data_i[1];
  assign unused_bits = ^{bus.addr_i[15:7], bus.addr_i[3:0], bus.data_i[31:DW]};

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rptr];
  // Full is judged on the current count only; a same-cycle pop does not make room.
  assign do_push  = txdata_wr && !full && !flush;
  assign load     = !empty && (!tvalid_q || bus.m_axis_tready_i);

`ifdef AXIS_TX_TLAST_EN
  assign push_dat = {bus.data_i[31], bus.data_i[DW-1:0]};
`else
  assign push_dat = bus.data_i[DW-1:0];
`endif

  always_ff @(posedge axis_aclk_i) begin
    if (do_push) begin
      mem[wptr] <= push_dat;
    end
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (load)    rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(load);
    end
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      overflow <= 1'b0;
    end else if (txdata_wr && full && !flush) begin
      overflow <= 1'b1;
    end else if (clr_sticky) begin
      overflow <= 1'b0;
    end
  end

  // Output slot: holds its word until the consumer takes it; flush never touches it.
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else if (load) begin
      tvalid_q <= 1'b1;
      tdata_q  <= head_dat[DW-1:0];
`ifdef AXIS_TX_TLAST_EN
      tlast_q  <= head_dat[FW-1];
`else
      tlast_q  <= 1'b0;
`endif
    end else if (bus.m_axis_tready_i) begin
      tvalid_q <= 1'b0;
    end
  end

`ifdef AXIS_TX_TLAST_EN
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      last_sent <= 1'b0;
    end else if (tvalid_q && bus.m_axis_tready_i && tlast_q) begin
      last_sent <= 1'b1;
    end else if (clr_sticky) begin
      last_sent <= 1'b0;
    end
  end
`else
  assign last_sent = 1'b0;
`endif

  always_comb begin
    status       = '0;
    status[15:8] = 8'(count);
    status[4]    = last_sent;
    status[3]    = overflow;
    status[2]    = empty;
    status[1]    = full;
    status[0]    = tvalid_q;
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      data_q <= '0;
    end else if (access) begin
      data_q <= (sel == OFF_STATUS) ? status : '0;
    end
  end

  assign bus.data_access_o   = access;
  assign bus.data_o          = data_q;
  assign bus.m_axis_tvalid_o = tvalid_q;
  assign bus.m_axis_tdata_o  = tdata_q;
  assign bus.m_axis_tlast_o  = tlast_q;
endmodule

// File: tb/tb_if_axis_tx.sv
// Directed bench for if_axis_tx: CPU register accesses plus a stream scoreboard.
// Inputs change 1ns after the rising edge; the stream is observed on the falling edge.
`timescale 1ns/1ps
module tb_if_axis_tx;
  localparam logic [31:0] A_STATUS = 32'hE4A9_0010;
  localparam logic [31:0] A_TXDATA = 32'hE4A9_0020;
  localparam logic [31:0] A_CTRL   = 32'hE4A9_0030;
`ifdef AXIS_TX_TLAST_EN
  localparam logic TL = 1'b1;
`else
  localparam logic TL = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  if_axis_tx_if #(.AXIS_DATA_WIDTH(8)) bus ();

  if_axis_tx #(
    .SOC_SEGMENT(8'hE4), .SOC_CLASS(8'hA9), .AXIS_DATA_WIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .axis_aclk_i   (clk),
    .axis_aresetn_i(rstn),
    .bus           (bus)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  int          hs_before;
  logic [8:0]  exp_q[$];
  logic        prev_hold = 1'b0;
  logic [8:0]  prev_word = '0;
  logic [8:0]  exp_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr_i   = a;
    bus.data_i   = d;
    bus.data_w_i = 1'b1;
    cyc();
    bus.data_w_i = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    bus.addr_i   = a;
    bus.data_w_i = 1'b0;
    cyc();
    bus.addr_i   = '0;
    check(tag, bus.data_o, e);
  endtask

  // Stream monitor: a word seen valid+ready here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_tvalid", 32'(bus.m_axis_tvalid_o), 32'h1);
        check("hold_word", 32'({bus.m_axis_tlast_o, bus.m_axis_tdata_o}), 32'(prev_word));
      end
      if (bus.m_axis_tvalid_o && bus.m_axis_tready_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $error("FAIL unexpected_word observed=%h required=none",
                 {bus.m_axis_tlast_o, bus.m_axis_tdata_o});
        end else begin
          exp_word = exp_q.pop_front();
          check("stream_word", 32'({bus.m_axis_tlast_o, bus.m_axis_tdata_o}), 32'(exp_word));
        end
      end
      prev_hold = bus.m_axis_tvalid_o && !bus.m_axis_tready_i;
      prev_word = {bus.m_axis_tlast_o, bus.m_axis_tdata_o};
    end
  end

  initial begin
    bus.addr_i          = '0;
    bus.data_i          = '0;
    bus.data_w_i        = 1'b0;
    bus.m_axis_tready_i = 1'b0;
    repeat (3) cyc();

    // Reset state
    check("rst_tvalid", 32'(bus.m_axis_tvalid_o), 32'h0);
    check("rst_tdata", 32'(bus.m_axis_tdata_o), 32'h0);
    check("rst_tlast", 32'(bus.m_axis_tlast_o), 32'h0);
    check("rst_data_o", bus.data_o, 32'h0);
    rstn = 1'b1;
    cyc();

    // Address window decode
    bus.addr_i = 32'hE4A9_0010; #1;
    check("access_hit", 32'(bus.data_access_o), 32'h1);
    bus.addr_i = 32'hE4AA_0010; #1;
    check("access_bad_class", 32'(bus.data_access_o), 32'h0);
    bus.addr_i = 32'h00A9_0010; #1;
    check("access_bad_seg", 32'(bus.data_access_o), 32'h0);
    bus.addr_i = '0;
    cyc();

    rd(A_STATUS, 32'h4, "reset_status");
    cyc();
    check("data_o_hold", bus.data_o, 32'h4);
    rd(A_TXDATA, 32'h0, "read_wo_zero");
    wr(A_STATUS, 32'hFFFF_FFFF);
    wr(32'hE5A9_0020, 32'h77);
    rd(A_STATUS, 32'h4, "ignored_writes");

    // Single word latency
    bus.m_axis_tready_i = 1'b1;
    exp_q.push_back({1'b0, 8'hA5});
    wr(A_TXDATA, 32'hA5);
    check("lat_edge_n", 32'(bus.m_axis_tvalid_o), 32'h0);
    cyc();
    check("lat_tvalid", 32'(bus.m_axis_tvalid_o), 32'h1);
    check("lat_tdata", 32'(bus.m_axis_tdata_o), 32'hA5);
    cyc();
    check("after_hs_tvalid", 32'(bus.m_axis_tvalid_o), 32'h0);
    rd(A_STATUS, 32'h4, "single_status");

    // Fill under backpressure, then overflow
    bus.m_axis_tready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back({1'b0, 8'(i)});
      wr(A_TXDATA, 32'(i));
    end
    rd(A_STATUS, 32'h0000_0403, "full_status");
    wr(A_TXDATA, 32'h06);
    rd(A_STATUS, 32'h0000_040B, "overflow_status");
    bus.m_axis_tready_i = 1'b1;
    repeat (8) cyc();
    check("drain_queue", 32'(exp_q.size()), 32'h0);
    check("drain_tvalid", 32'(bus.m_axis_tvalid_o), 32'h0);
    rd(A_STATUS, 32'h0000_000C, "overflow_sticky");
    wr(A_CTRL, 32'h2);
    rd(A_STATUS, 32'h4, "overflow_clear");

    // Long hold, then flush behind the held word
    bus.m_axis_tready_i = 1'b0;
    exp_q.push_back({1'b0, 8'h31});
    wr(A_TXDATA, 32'h31);
    wr(A_TXDATA, 32'h32);
    wr(A_TXDATA, 32'h33);
    repeat (10) cyc();
    check("held_tvalid", 32'(bus.m_axis_tvalid_o), 32'h1);
    check("held_tdata", 32'(bus.m_axis_tdata_o), 32'h31);
    wr(A_CTRL, 32'h1);
    rd(A_STATUS, 32'h0000_0005, "flush_status");
    bus.m_axis_tready_i = 1'b1;
    repeat (4) cyc();
    check("flush_queue", 32'(exp_q.size()), 32'h0);
    check("flush_tvalid", 32'(bus.m_axis_tvalid_o), 32'h0);

    // Back-to-back writes at full rate
    hs_before = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b0, 8'(8'h40 + i)});
      bus.addr_i   = A_TXDATA;
      bus.data_i   = 32'(8'h40 + i);
      bus.data_w_i = 1'b1;
      cyc();
    end
    bus.data_w_i = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    repeat (2) cyc();
    check("burst_handshakes", 32'(hs_cnt - hs_before), 32'h8);
    rd(A_STATUS, 32'h4, "burst_status");

    // tlast word
    bus.m_axis_tready_i = 1'b0;
    exp_q.push_back({TL, 8'h11});
    wr(A_TXDATA, 32'h8000_0011);
    cyc();
    check("tlast_flag", 32'(bus.m_axis_tlast_o), 32'(TL));
    check("tlast_tdata", 32'(bus.m_axis_tdata_o), 32'h11);
    bus.m_axis_tready_i = 1'b1;
    cyc();
    bus.m_axis_tready_i = 1'b0;
    rd(A_STATUS, {27'h0, TL, 4'h4}, "tlast_status");
    wr(A_CTRL, 32'h2);
    rd(A_STATUS, 32'h4, "tlast_clear");

    // Reset while a word is held
    wr(A_TXDATA, 32'h55);
    wr(A_TXDATA, 32'h56);
    cyc();
    check("pre_reset_tvalid", 32'(bus.m_axis_tvalid_o), 32'h1);
    rstn = 1'b0;
    #1;
    check("async_rst_tvalid", 32'(bus.m_axis_tvalid_o), 32'h0);
    check("async_rst_tdata", 32'(bus.m_axis_tdata_o), 32'h0);
    cyc();
    rstn = 1'b1;
    cyc();
    rd(A_STATUS, 32'h4, "post_reset_status");
    bus.m_axis_tready_i = 1'b1;
    repeat (3) cyc();
    check("final_queue", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
